mat_engine_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one matrix_transpose_3x3 engine between NREQ requesters
//  (e.g. Kalman predict and update stages). Wins a requester, streams its 3x3 operand into the

---
 rtl/mat_engine_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mat_engine_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_engine_arbiter.sv
// Round-robin sequencer that shares one 3x3 matrix engine between NREQ requesters:
// grant, stream the operand into the engine, start it, forward results, report completion.
module mat_engine_arbiter #(
    parameter int NREQ       = 2,
    parameter int M          = 3,
    parameter int P          = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_i,
    output logic [NREQ-1:0]            gnt_o,
    output logic [3:0]                 src_addr_o,
    input  logic [NREQ*DATA_WIDTH-1:0] src_data_i,
    output logic [NREQ-1:0]            res_wen_o,
    output logic [3:0]                 res_addr_o,
    output logic [DATA_WIDTH-1:0]      res_data_o,
    output logic [NREQ-1:0]            op_done_o,
    output logic [NREQ-1:0]            op_err_o,
    output logic                       eng_start_o,
    output logic [DATA_WIDTH-1:0]      eng_a_in_o,
    output logic [3:0]                 eng_a_addr_o,
    output logic                       eng_a_wen_o,
    input  logic [DATA_WIDTH-1:0]      eng_c_out_i,
    input  logic                       eng_c_valid_i,
    input  logic                       eng_done_i,
    input  logic [3:0]                 eng_idx_i
);
    localparam int N     = M * P;
    localparam int PTR_W = $clog2(NREQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0]       K_LAST   = 4'(N - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

    logic [2:0]            state_q, state_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [PTR_W-1:0]      gidx_q, gidx_d;
    logic [PTR_W-1:0]      rr_q, rr_d;
    logic [3:0]            k_q, k_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  err_q, err_d;
    logic [NREQ-1:0]       res_wen_q, res_wen_d;
    logic [3:0]            res_addr_q, res_addr_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;

    logic [DATA_WIDTH-1:0] src_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_src_unpack
        assign src_arr[gi] = src_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // First requester at or after the rr pointer, wrapping modulo NREQ.
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W:0]   arb_sum;
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        arb_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            arb_sum = {1'b0, rr_q} + (PTR_W+1)'(i);
            if (arb_sum >= (PTR_W+1)'(NREQ)) begin
                arb_sum = arb_sum - (PTR_W+1)'(NREQ);
            end
            if (!win_found && req_i[arb_sum[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = arb_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gidx_d     = gidx_q;
        rr_d       = rr_q;
        k_d        = k_q;
        wd_d       = wd_q;
        err_d      = err_q;
        res_wen_d  = '0;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;

        // A result arriving with eng_done is still forwarded, landing in the DONE cycle.
        if (eng_c_valid_i && (state_q == S_RUN || state_q == S_DONE)) begin
            res_wen_d  = gnt_q;
            res_addr_d = eng_idx_i;
            res_data_d = eng_c_out_i;
        end

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    gidx_d         = win_idx;
                    k_d            = '0;
                    err_d          = 1'b0;
                    state_d        = S_LOAD;
                end
            end
            S_LOAD: begin
                if (k_q == K_LAST) begin
                    state_d = S_START;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (eng_done_i) begin
                    state_d = S_DONE;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                rr_d    = (gidx_q == PTR_LAST) ? '0 : gidx_q + PTR_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            gidx_q     <= '0;
            rr_q       <= '0;
            k_q        <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            res_wen_q  <= '0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gidx_q     <= gidx_d;
            rr_q       <= rr_d;
            k_q        <= k_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
            res_wen_q  <= res_wen_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign src_addr_o   = (state_q == S_LOAD) ? k_q : '0;
    assign eng_a_addr_o = (state_q == S_LOAD) ? k_q : '0;
    assign eng_a_wen_o  = (state_q == S_LOAD);
    assign eng_a_in_o   = (state_q == S_LOAD) ? src_arr[gidx_q] : '0;
    assign eng_start_o  = (state_q == S_START);
    assign op_done_o    = (state_q == S_DONE && !err_q) ? gnt_q : '0;
    assign op_err_o     = (state_q == S_DONE &&  err_q) ? gnt_q : '0;
    assign res_wen_o    = res_wen_q;
    assign res_addr_o   = res_addr_q;
    assign res_data_o   = res_data_q;

endmodule

// File: tb/tb_mat_engine_arbiter.sv
// Bench for mat_engine_arbiter: stub transpose engine, vector table, corner sequences, random ops.
module tb_mat_engine_arbiter;
    localparam int NREQ = 2;
    localparam int DW = 32;
    localparam int TIMEOUT = 64;
    localparam int MODE_NORMAL = 0;
    localparam int MODE_LATE = 1;
    localparam int MODE_HANG = 2;
    localparam logic [DW-1:0] SENTINEL = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    gnt, res_wen, op_done, op_err;
    logic [3:0]         src_addr, res_addr, eng_a_addr, eng_idx;
    logic [NREQ*DW-1:0] src_data;
    logic [DW-1:0]      res_data, eng_a_in, eng_c_out;
    logic               eng_start, eng_a_wen, eng_c_valid, eng_done;

    always #5 clk = ~clk;

    mat_engine_arbiter #(.NREQ(NREQ), .M(3), .P(3), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt), .src_addr_o(src_addr),
        .src_data_i(src_data), .res_wen_o(res_wen), .res_addr_o(res_addr),
        .res_data_o(res_data), .op_done_o(op_done), .op_err_o(op_err),
        .eng_start_o(eng_start), .eng_a_in_o(eng_a_in), .eng_a_addr_o(eng_a_addr),
        .eng_a_wen_o(eng_a_wen), .eng_c_out_i(eng_c_out), .eng_c_valid_i(eng_c_valid),
        .eng_done_i(eng_done), .eng_idx_i(eng_idx)
    );

    // Requester operand RAMs, read combinationally.
    logic [DW-1:0] operand [NREQ][16];
    always_comb begin
        src_data = '0;
        for (int r = 0; r < NREQ; r++) src_data[r*DW +: DW] = operand[r][src_addr];
    end

    // Stub transpose engine.
    logic [DW-1:0] eng_mem [16];
    int eng_mode = MODE_NORMAL;
    int eng_lat = 0;
    int spur_req = 0;
    int spur_ack;
    initial begin
        eng_c_valid = 1'b0; eng_done = 1'b0; eng_idx = '0; eng_c_out = '0; spur_ack = 0;
        forever begin
            @(negedge clk);
            if (eng_a_wen) eng_mem[eng_a_addr] = eng_a_in;
            if (eng_start) begin
                repeat (eng_lat) @(posedge clk);
                for (int e = 0; e < 9; e++) begin
                    @(posedge clk); #1;
                    eng_c_valid = 1'b1;
                    eng_idx     = 4'(e);
                    eng_c_out   = eng_mem[(e % 3) * 3 + e / 3];
                    eng_done    = (eng_mode == MODE_NORMAL && e == 8);
                end
                @(posedge clk); #1;
                eng_c_valid = 1'b0; eng_done = 1'b0; eng_idx = '0;
                if (eng_mode == MODE_LATE) begin
                    repeat (3) @(posedge clk);
                    #1 eng_done = 1'b1;
                    @(posedge clk);
                    #1 eng_done = 1'b0;
                end
            end else if (spur_req != spur_ack) begin
                spur_ack = spur_req;
                @(posedge clk); #1;
                eng_c_valid = 1'b1; eng_idx = 4'd3; eng_c_out = 32'd77;
                @(posedge clk); #1;
                eng_c_valid = 1'b0; eng_idx = '0;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_start, start_cyc, n_res, n_res_at_done, done_cyc;
    bit done_seen;
    logic [NREQ-1:0] done_vec, err_vec;
    logic [DW-1:0] res_mem [NREQ][16];
    int ptr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of observation; every wait in the bench goes through here.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (eng_start) begin n_start++; start_cyc = cyc; end
        if (res_wen != '0) begin
            chk("res_wen_owner", 64'(res_wen), 64'(gnt));
            for (int r = 0; r < NREQ; r++) if (res_wen[r]) res_mem[r][res_addr] = res_data;
            n_res++;
        end
        if ((op_done | op_err) != '0) begin
            chk("done_owner", 64'(op_done | op_err), 64'(gnt));
            chk("done_err_excl", 64'(op_done & op_err), 64'd0);
            done_seen = 1'b1; done_vec = op_done; err_vec = op_err;
            done_cyc = cyc; n_res_at_done = n_res;
        end
    endtask

    function automatic int arb(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic do_op(input string tag, input logic [NREQ-1:0] r, input int mode, input int lat,
                         input int exp_g, input bit exp_err, input bit drop);
        int w, bad;
        logic [NREQ-1:0] ev;
        ev = onehot(exp_g);
        for (int e = 0; e < 16; e++) res_mem[exp_g][e] = SENTINEL;
        eng_mode = mode; eng_lat = lat; n_start = 0; n_res = 0; done_seen = 1'b0; req = r;
        w = 0;
        while (gnt == '0 && w < 50) begin tick(); w++; end
        chk({tag, "_grant"}, 64'(gnt), 64'(ev));
        if (drop) req = '0;
        w = 0;
        while (!done_seen && w < 200) begin tick(); w++; end
        req = '0;
        chk({tag, "_completed"}, 64'(done_seen), 64'd1);
        chk({tag, "_op_done"}, 64'(done_vec), exp_err ? 64'd0 : 64'(ev));
        chk({tag, "_op_err"}, 64'(err_vec), exp_err ? 64'(ev) : 64'd0);
        chk({tag, "_starts"}, 64'(n_start), 64'd1);
        bad = 0;
        for (int e = 0; e < 9; e++) if (eng_mem[e] !== operand[exp_g][e]) bad++;
        chk({tag, "_load"}, 64'(bad), 64'd0);
        if (exp_err) begin
            chk({tag, "_timeout_lat"}, 64'(done_cyc - start_cyc), 64'(TIMEOUT + 1));
        end else begin
            chk({tag, "_res_before_done"}, 64'(n_res_at_done), 64'd9);
            for (int e = 0; e < 9; e++)
                chk({tag, "_res"}, 64'(res_mem[exp_g][e]), 64'(operand[exp_g][(e % 3) * 3 + e / 3]));
        end
        $display("op %s req=%b gnt=%b done=%b err=%b cyc=%0d", tag, r, ev, done_vec, err_vec, done_cyc);
        ptr = (exp_g + 1) % NREQ;
        tick();
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        int mode;
        int lat;
        int exp_g;
        bit exp_err;
        bit drop;
    } vec_t;

    initial begin
        vec_t vecs [8];
        int lit [9] = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
        int w, g;
        logic [NREQ-1:0] seen;

        vecs[0] = '{2'b01, MODE_NORMAL, 2, 0, 1'b0, 1'b0};
        vecs[1] = '{2'b11, MODE_NORMAL, 0, 1, 1'b0, 1'b0};
        vecs[2] = '{2'b11, MODE_LATE,   3, 0, 1'b0, 1'b0};
        vecs[3] = '{2'b10, MODE_NORMAL, 1, 1, 1'b0, 1'b1};
        vecs[4] = '{2'b10, MODE_HANG,   0, 1, 1'b1, 1'b0};
        vecs[5] = '{2'b01, MODE_NORMAL, 4, 0, 1'b0, 1'b0};
        vecs[6] = '{2'b01, MODE_NORMAL, 0, 0, 1'b0, 1'b0};
        vecs[7] = '{2'b11, MODE_NORMAL, 5, 1, 1'b0, 1'b0};

        for (int e = 0; e < 16; e++) begin
            operand[0][e] = (e < 9) ? DW'(e + 1) : '0;
            operand[1][e] = $urandom;
        end
        rst = 1'b1; req = '0;
        tick();
        chk("reset_ctrl", 64'({gnt, res_wen, op_done, op_err, eng_start, eng_a_wen}), 64'd0);
        chk("reset_data", 64'(res_data | eng_a_in | {src_addr, res_addr, eng_a_addr}), 64'd0);
        tick();
        #1 rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].req, vecs[i].mode, vecs[i].lat,
                  vecs[i].exp_g, vecs[i].exp_err, vecs[i].drop);
            if (i == 0)
                for (int e = 0; e < 9; e++) chk("t1_literal", 64'(res_mem[0][e]), 64'(lit[e]));
            if (vecs[i].drop) begin
                seen = '0;
                repeat (10) begin tick(); seen |= gnt; end
                chk("no_regrant_after_drop", 64'(seen), 64'd0);
            end
        end

        // Stray engine result while idle must not reach any requester.
        n_res = 0; spur_req++;
        repeat (4) tick();
        chk("spurious_valid_ignored", 64'(n_res), 64'd0);

        // Both requests held: strict alternation without dropping req.
        req = 2'b11; eng_mode = MODE_NORMAL; eng_lat = 1;
        for (int t = 0; t < 4; t++) begin
            g = arb(2'b11, ptr);
            w = 0;
            while (gnt == '0 && w < 50) begin tick(); w++; end
            chk("held_grant", 64'(gnt), 64'(onehot(g)));
            done_seen = 1'b0; w = 0;
            while (!done_seen && w < 200) begin tick(); w++; end
            if (t == 3) req = '0;
            chk("held_done", 64'(done_vec), 64'(onehot(g)));
            $display("op held%0d req=11 gnt=%b done=%b", t, onehot(g), done_vec);
            ptr = (g + 1) % NREQ;
            tick();
        end

        // Reset in the middle of RUN must clear everything, including the rr pointer.
        do_op("pre_rst", 2'b01, MODE_NORMAL, 0, arb(2'b01, ptr), 1'b0, 1'b0);
        req = 2'b01; eng_mode = MODE_HANG; eng_lat = 0; n_start = 0;
        w = 0;
        while (n_start == 0 && w < 50) begin tick(); w++; end
        repeat (5) tick();
        chk("mid_run_gnt", 64'(gnt), 64'b01);
        #2 rst = 1'b1;
        #1;
        chk("rst_ctrl", 64'({gnt, res_wen, op_done, op_err, eng_start, eng_a_wen}), 64'd0);
        chk("rst_data", 64'(res_data | eng_a_in | {src_addr, res_addr, eng_a_addr}), 64'd0);
        req = '0; done_seen = 1'b0;
        repeat (2) tick();
        #1 rst = 1'b0;
        ptr = 0;
        repeat (15) tick();
        chk("no_done_after_rst", 64'(done_seen), 64'd0);
        $display("op reset mid-run gnt=%b", gnt);
        do_op("post_rst_11", 2'b11, MODE_NORMAL, 0, arb(2'b11, ptr), 1'b0, 1'b0);
        do_op("post_rst_10", 2'b10, MODE_NORMAL, 2, arb(2'b10, ptr), 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            logic [NREQ-1:0] rr;
            for (int r = 0; r < NREQ; r++)
                for (int e = 0; e < 16; e++) operand[r][e] = $urandom;
            rr = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            do_op($sformatf("rand%0d", i), rr, int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                  arb(rr, ptr), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule
